// File: rtl/if_id_stage.sv
// IF/ID pipeline register: latches the fetch PC and synchronous-ROM data.
// A one-entry hold buffer keeps ROM data that would otherwise be lost during a stall.
module if_id_stage #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_INST   = 32'h00000000,
  parameter int                    CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_cur,
  input  logic                  stall_next,
  input  logic                  flush,
  input  logic                  rom_en,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic [DATA_WIDTH-1:0] rom_read_data,
  output logic [ADDR_WIDTH-1:0] id_pc,
  output logic [DATA_WIDTH-1:0] id_inst,
  output logic                  id_valid,
  output logic                  id_exc_adel,
  output logic [CNT_WIDTH-1:0]  fetch_cnt,
  output logic [CNT_WIDTH-1:0]  bubble_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [ADDR_WIDTH-1:0] id_pc_q, id_pc_d;
  logic [DATA_WIDTH-1:0] id_inst_q, id_inst_d;
  logic                  id_valid_q, id_valid_d;
  logic                  id_adel_q, id_adel_d;
  logic [CNT_WIDTH-1:0]  fetch_cnt_q, fetch_cnt_d;
  logic [CNT_WIDTH-1:0]  bubble_cnt_q, bubble_cnt_d;
  logic                  hold_valid_q, hold_valid_d;
  logic [DATA_WIDTH-1:0] hold_inst_q, hold_inst_d;

  logic misaligned;
  assign misaligned = (pc[1:0] != 2'b00);

  always_comb begin
    id_pc_d      = id_pc_q;
    id_inst_d    = id_inst_q;
    id_valid_d   = id_valid_q;
    id_adel_d    = id_adel_q;
    fetch_cnt_d  = fetch_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    hold_valid_d = hold_valid_q;
    hold_inst_d  = hold_inst_q;

    if (flush) begin
      id_pc_d      = '0;
      id_inst_d    = NOP_INST;
      id_valid_d   = 1'b0;
      id_adel_d    = 1'b0;
      hold_valid_d = 1'b0;
      bubble_cnt_d = bubble_cnt_q + CNT_ONE;
    end else if (stall_cur) begin
      // ROM data is only present for one cycle, so capture the first word seen while stalled
      if (!hold_valid_q && rom_en) begin
        hold_inst_d  = rom_read_data;
        hold_valid_d = 1'b1;
      end
      if (!stall_next) begin
        id_inst_d    = NOP_INST;
        id_valid_d   = 1'b0;
        id_adel_d    = 1'b0;
        bubble_cnt_d = bubble_cnt_q + CNT_ONE;
      end
    end else begin
      id_pc_d      = pc;
      id_valid_d   = rom_en;
      hold_valid_d = 1'b0;
      if (rom_en) begin
        fetch_cnt_d = fetch_cnt_q + CNT_ONE;
        if (misaligned) begin
          id_inst_d = NOP_INST;
          id_adel_d = 1'b1;
        end else begin
          id_inst_d = hold_valid_q ? hold_inst_q : rom_read_data;
          id_adel_d = 1'b0;
        end
      end else begin
        id_inst_d    = NOP_INST;
        id_adel_d    = 1'b0;
        bubble_cnt_d = bubble_cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_pc_q      <= '0;
      id_inst_q    <= NOP_INST;
      id_valid_q   <= 1'b0;
      id_adel_q    <= 1'b0;
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
      hold_valid_q <= 1'b0;
      hold_inst_q  <= '0;
    end else begin
      id_pc_q      <= id_pc_d;
      id_inst_q    <= id_inst_d;
      id_valid_q   <= id_valid_d;
      id_adel_q    <= id_adel_d;
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
      hold_valid_q <= hold_valid_d;
      hold_inst_q  <= hold_inst_d;
    end
  end

  assign id_pc       = id_pc_q;
  assign id_inst     = id_inst_q;
  assign id_valid    = id_valid_q;
  assign id_exc_adel = id_adel_q;
  assign fetch_cnt   = fetch_cnt_q;
  assign bubble_cnt  = bubble_cnt_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard bench for if_id_stage: directed cycles push expected ID state, a monitor compares.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_cur = 1'b0, stall_next = 1'b0, flush = 1'b0, rom_en = 1'b0;
  logic [31:0] pc = '0, rom_read_data = '0;
  logic [31:0] id_pc, id_inst, fetch_cnt, bubble_cnt;
  logic        id_valid, id_exc_adel;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        v;
    logic        adel;
    logic [31:0] f;
    logic [31:0] b;
  } exp_t;

  exp_t sb[$];

  if_id_stage dut (
    .clk(clk), .rst(rst), .stall_cur(stall_cur), .stall_next(stall_next),
    .flush(flush), .rom_en(rom_en), .pc(pc), .rom_read_data(rom_read_data),
    .id_pc(id_pc), .id_inst(id_inst), .id_valid(id_valid), .id_exc_adel(id_exc_adel),
    .fetch_cnt(fetch_cnt), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst) assert (!(stall_next && !stall_cur)) else $error("illegal stall_next without stall_cur");
  end

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  int popped = 0;
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      popped++;
      chk("id_pc",       popped, id_pc,                 e.pc);
      chk("id_inst",     popped, id_inst,               e.inst);
      chk("id_valid",    popped, {31'b0, id_valid},     {31'b0, e.v});
      chk("id_exc_adel", popped, {31'b0, id_exc_adel},  {31'b0, e.adel});
      chk("fetch_cnt",   popped, fetch_cnt,             e.f);
      chk("bubble_cnt",  popped, bubble_cnt,            e.b);
    end
  end

  task automatic step(input logic r, input logic sc, input logic sn, input logic fl,
                      input logic en, input logic [31:0] p, input logic [31:0] d,
                      input logic [31:0] epc, input logic [31:0] einst,
                      input logic ev, input logic ea, input int ef, input int eb);
    exp_t e;
    @(negedge clk);
    rst = r; stall_cur = sc; stall_next = sn; flush = fl;
    rom_en = en; pc = p; rom_read_data = d;
    e.pc = epc; e.inst = einst; e.v = ev; e.adel = ea;
    e.f = ef; e.b = eb;
    sb.push_back(e);
  endtask

  initial begin
    // Reset with arbitrary (legal-stall) inputs
    for (int i = 0; i < 2; i++) begin
      logic sc_r;
      sc_r = 1'($urandom);
      step(1, sc_r, sc_r & 1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom,
           32'h0, 32'h0, 0, 0, 0, 0);
    end
    // Stream
    step(0, 0, 0, 0, 1, 32'hBFC00000, 32'h11, 32'hBFC00000, 32'h11, 1, 0, 1, 0);
    step(0, 0, 0, 0, 1, 32'hBFC00004, 32'h22, 32'hBFC00004, 32'h22, 1, 0, 2, 0);
    step(0, 0, 0, 0, 1, 32'hBFC00008, 32'h33, 32'hBFC00008, 32'h33, 1, 0, 3, 0);
    // Hold: outputs frozen, first word captured
    step(0, 1, 1, 0, 1, 32'hBFC0000C, 32'h44,   32'hBFC00008, 32'h33, 1, 0, 3, 0);
    step(0, 1, 1, 0, 1, 32'hBFC0000C, 32'hDEAD, 32'hBFC00008, 32'h33, 1, 0, 3, 0);
    step(0, 1, 1, 0, 1, 32'hBFC0000C, 32'hBEEF, 32'hBFC00008, 32'h33, 1, 0, 3, 0);
    step(0, 0, 0, 0, 1, 32'hBFC0000C, 32'h55,   32'hBFC0000C, 32'h44, 1, 0, 4, 0);
    step(0, 0, 0, 0, 1, 32'hBFC00010, 32'h55,   32'hBFC00010, 32'h55, 1, 0, 5, 0);
    // Bubble then advance with held word
    step(0, 1, 0, 0, 1, 32'hBFC00014, 32'h66,   32'hBFC00010, 32'h0,  0, 0, 5, 1);
    step(0, 0, 0, 0, 1, 32'hBFC00014, 32'h77,   32'hBFC00014, 32'h66, 1, 0, 6, 1);
    // Flush during stall clears hold buffer
    step(0, 1, 1, 0, 1, 32'hBFC00018, 32'h88,   32'hBFC00014, 32'h66, 1, 0, 6, 1);
    step(0, 1, 1, 1, 1, 32'hBFC00018, 32'h99,   32'h0,        32'h0,  0, 0, 6, 2);
    step(0, 0, 0, 0, 1, 32'hBFC00380, 32'hABCD, 32'hBFC00380, 32'hABCD, 1, 0, 7, 2);
    // Misaligned fetch, then rom_en=0 slot, then normal
    step(0, 0, 0, 0, 1, 32'hBFC00002, 32'h1234, 32'hBFC00002, 32'h0,  1, 1, 8, 2);
    step(0, 0, 0, 0, 0, 32'hBFC00004, 32'h5678, 32'hBFC00004, 32'h0,  0, 0, 8, 3);
    step(0, 0, 0, 0, 1, 32'hBFC00008, 32'hCAFE, 32'hBFC00008, 32'hCAFE, 1, 0, 9, 3);
    // Flush without stall
    step(0, 0, 0, 1, 1, 32'hBFC0000C, 32'hF00D, 32'h0,        32'h0,  0, 0, 9, 4);
    // Two bubbles: hold buffer keeps first word
    step(0, 1, 0, 0, 1, 32'hBFC0000C, 32'h111,  32'h0,        32'h0,  0, 0, 9, 5);
    step(0, 1, 0, 0, 1, 32'hBFC0000C, 32'h222,  32'h0,        32'h0,  0, 0, 9, 6);
    step(0, 0, 0, 0, 1, 32'hBFC0000C, 32'h333,  32'hBFC0000C, 32'h111, 1, 0, 10, 6);
    // Reset mid-stall discards hold buffer
    step(0, 1, 1, 0, 1, 32'hBFC00010, 32'h444,  32'hBFC0000C, 32'h111, 1, 0, 10, 6);
    step(1, 1, 1, 0, 1, 32'hBFC00010, 32'h444,  32'h0,        32'h0,  0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'hBFC00020, 32'h555,  32'hBFC00020, 32'h555, 1, 0, 1, 0);

    begin
      int budget;
      budget = 0;
      while (sb.size() > 0 && budget < 10) begin
        @(posedge clk);
        budget++;
      end
      #2;
      checks++;
      if (sb.size() != 0) begin
        errors++;
        $display("FAIL drain: %0d expectations left, required 0", sb.size());
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
